// File: rtl/car_pkg.sv
// Shared types and default parameters for the clock-and-reset block.
// Used by the clk1 sequencer and reusable by the other clock domains.
package car_pkg;

   typedef enum logic [2:0] {
      RESET = 3'd0,
      HOLD  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      GATED = 3'd4
   } car_ctrl_state_t;

   localparam int CAR_SYNC_STAGES = 2;
   localparam int CAR_RST_HOLD    = 8;
   localparam int CAR_IDLE_CYCLES = 16;
   localparam int CAR_CNT_W       = 8;

endpackage

// File: rtl/car_ctrl_if.sv
// Request/status bundle between software gating logic and the clk1 sequencer.
// slave = sequencer side, master = requester side.
interface car_ctrl_if;

   logic       sw_rst_req;
   logic       gate_req;
   logic       busy;
   logic       en1;
   logic       rst_n_seq;
   logic       gate_ack;
   logic       auto_gated;
   logic [2:0] state_o;

   modport master (
      output sw_rst_req, gate_req, busy,
      input  en1, rst_n_seq, gate_ack, auto_gated, state_o
   );

   modport slave (
      input  sw_rst_req, gate_req, busy,
      output en1, rst_n_seq, gate_ack, auto_gated, state_o
   );

endinterface

// File: rtl/car_rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES edges.
// Clock-domain agnostic so the clk2 side can reuse it unchanged.
module car_rst_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   output logic rst_n_sync
);

   logic [SYNC_STAGES-1:0] sync_reg;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_n_sync = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/car_ctrl.sv
// clk1 clock-enable and reset sequencer driving the gate cell en1 and sequenced reset.
// Optional idle auto-gating is built in when CAR_CTRL_AUTO_GATE_EN is defined.
module car_ctrl
   import car_pkg::*;
#(
   parameter int SYNC_STAGES = CAR_SYNC_STAGES,
   parameter int RST_HOLD    = CAR_RST_HOLD,
   parameter int IDLE_CYCLES = CAR_IDLE_CYCLES,
   parameter int CNT_W       = CAR_CNT_W
) (
   input  logic      clk1,
   input  logic      rst_n1,
   car_ctrl_if.slave ctrl
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   if (SYNC_STAGES < 2 || RST_HOLD < 1 || IDLE_CYCLES < 1 ||
       RST_HOLD > 2**CNT_W || IDLE_CYCLES > 2**CNT_W) begin : g_bad_params
      $error("car_ctrl: illegal parameter combination");
   end

   car_ctrl_state_t  state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             en1_reg, en1_next;
   logic             rst_n_seq_reg, rst_n_seq_next;
   logic             gate_ack_reg, gate_ack_next;
   logic             rst_sync;

`ifdef CAR_CTRL_AUTO_GATE_EN
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   logic auto_reg, auto_next;
`endif

   car_rst_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rst_sync (
      .clk        (clk1),
      .arst_n     (rst_n1),
      .rst_n_sync (rst_sync)
   );

   always_ff @(posedge clk1 or negedge rst_n1) begin
      if (!rst_n1) begin
         state_reg     <= RESET;
         cnt_reg       <= '0;
         en1_reg       <= 1'b1;
         rst_n_seq_reg <= 1'b0;
         gate_ack_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         en1_reg       <= en1_next;
         rst_n_seq_reg <= rst_n_seq_next;
         gate_ack_reg  <= gate_ack_next;
      end
   end

`ifdef CAR_CTRL_AUTO_GATE_EN
   always_ff @(posedge clk1 or negedge rst_n1) begin
      if (!rst_n1) begin
         auto_reg <= 1'b0;
      end else begin
         auto_reg <= auto_next;
      end
   end
`endif

   // cnt_reg is shared: HOLD countdown, DRAIN idle samples, RUN idle timer.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
`ifdef CAR_CTRL_AUTO_GATE_EN
      auto_next  = auto_reg;
`endif
      case (state_reg)
         RESET: begin
            if (rst_sync) begin
               state_next = HOLD;
               cnt_next   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (ctrl.sw_rst_req) begin
               cnt_next = HOLD_LOAD;
            end else if (cnt_reg == '0) begin
               state_next = RUN;
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
            end
         end
         RUN: begin
            if (ctrl.gate_req) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end
`ifdef CAR_CTRL_AUTO_GATE_EN
            else if (ctrl.busy) begin
               cnt_next = '0;
            end else if (cnt_reg == IDLE_LAST) begin
               state_next = GATED;
               cnt_next   = '0;
               auto_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
`endif
         end
         DRAIN: begin
            if (!ctrl.gate_req) begin
               state_next = RUN;
               cnt_next   = '0;
            end else if (ctrl.busy) begin
               cnt_next = '0;
            end else if (cnt_reg != '0) begin
               state_next = GATED;
               cnt_next   = '0;
            end else begin
               cnt_next = CNT_ONE;
            end
         end
         GATED: begin
`ifdef CAR_CTRL_AUTO_GATE_EN
            if (auto_reg) begin
               if (ctrl.busy || ctrl.gate_req) begin
                  state_next = RUN;
                  auto_next  = 1'b0;
               end
            end else if (!ctrl.gate_req) begin
               state_next = RUN;
            end
`else
            if (!ctrl.gate_req) begin
               state_next = RUN;
            end
`endif
         end
         default: begin
            state_next = RESET;
            cnt_next   = '0;
         end
      endcase

      // Software reset overrides every gating decision made above.
      if (ctrl.sw_rst_req && (state_reg inside {RUN, DRAIN, GATED})) begin
         state_next = HOLD;
         cnt_next   = HOLD_LOAD;
`ifdef CAR_CTRL_AUTO_GATE_EN
         auto_next  = 1'b0;
`endif
      end

      en1_next       = (state_next != GATED);
      rst_n_seq_next = (state_next inside {RUN, DRAIN, GATED});
`ifdef CAR_CTRL_AUTO_GATE_EN
      gate_ack_next  = (state_next == GATED) && !auto_next;
`else
      gate_ack_next  = (state_next == GATED);
`endif
   end

   assign ctrl.en1       = en1_reg;
   assign ctrl.rst_n_seq = rst_n_seq_reg;
   assign ctrl.gate_ack  = gate_ack_reg;
   assign ctrl.state_o   = state_reg;
`ifdef CAR_CTRL_AUTO_GATE_EN
   assign ctrl.auto_gated = auto_reg;
`else
   assign ctrl.auto_gated = 1'b0;
`endif

endmodule

// File: tb/tb_car_ctrl.sv
// Self-checking bench for car_ctrl: directed scenarios plus random traffic
// compared every edge against a timestamp-based reference model.
module tb_car_ctrl;

   localparam int SYNC = 2;
   localparam int HOLD = 8;
   localparam int IDLE = 16;
`ifdef CAR_CTRL_AUTO_GATE_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk1   = 1'b0;
   logic rst_n1 = 1'b1;
   logic sw_r   = 1'b0;
   logic gr_r   = 1'b0;
   logic bz_r   = 1'b0;

   int total = 0;
   int bad   = 0;

   car_ctrl_if ctrl_if ();

   assign ctrl_if.sw_rst_req = sw_r;
   assign ctrl_if.gate_req   = gr_r;
   assign ctrl_if.busy       = bz_r;

   car_ctrl #(
      .SYNC_STAGES (SYNC),
      .RST_HOLD    (HOLD),
      .IDLE_CYCLES (IDLE),
      .CNT_W       (8)
   ) dut (
      .clk1   (clk1),
      .rst_n1 (rst_n1),
      .ctrl   (ctrl_if)
   );

   always #5 clk1 = ~clk1;

   // Reference model: e counts edges since reset release; the sequenced
   // reset is released once e reaches hold_end.
   int e;
   int hold_end;
   bit m_gated, m_auto, m_drain;
   int didle, ridle;

   task automatic chk_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, e, got, exp);
      end
   endtask

   task automatic model_reset();
      e        = 0;
      hold_end = 1 << 30;
      m_gated  = 1'b0;
      m_auto   = 1'b0;
      m_drain  = 1'b0;
      didle    = 0;
      ridle    = 0;
   endtask

   task automatic model_clear_activity();
      m_gated = 1'b0;
      m_auto  = 1'b0;
      m_drain = 1'b0;
      didle   = 0;
      ridle   = 0;
   endtask

   task automatic model_edge(input bit sw, input bit gr, input bit bz);
      e++;
      if (e <= SYNC) return;
      if (e == SYNC + 1) begin
         hold_end = e + HOLD;
         return;
      end
      if (sw || (e - 1 < hold_end)) begin
         if (sw) hold_end = e + HOLD;
         model_clear_activity();
         return;
      end
      if (m_gated) begin
         if (m_auto) begin
            if (bz || gr) begin
               m_gated = 1'b0;
               m_auto  = 1'b0;
            end
         end else if (!gr) begin
            m_gated = 1'b0;
         end
         ridle = 0;
      end else if (m_drain) begin
         if (!gr) begin
            m_drain = 1'b0;
         end else if (bz) begin
            didle = 0;
         end else begin
            didle++;
            if (didle == 2) begin
               m_drain = 1'b0;
               m_gated = 1'b1;
            end
         end
         ridle = 0;
      end else begin
         if (gr) begin
            m_drain = 1'b1;
            didle   = 0;
            ridle   = 0;
         end else if (AUTO) begin
            if (bz) begin
               ridle = 0;
            end else begin
               ridle++;
               if (ridle == IDLE) begin
                  m_gated = 1'b1;
                  m_auto  = 1'b1;
                  ridle   = 0;
               end
            end
         end
      end
   endtask

   task automatic check_outputs();
      bit active;
      logic [3:0] exp_state;
      active = (e > SYNC) && (e >= hold_end);
      if (e <= SYNC)      exp_state = 4'd0;
      else if (!active)   exp_state = 4'd1;
      else if (m_gated)   exp_state = 4'd4;
      else if (m_drain)   exp_state = 4'd3;
      else                exp_state = 4'd2;
      chk_val("state_o",    {1'b0, ctrl_if.state_o}, exp_state);
      chk_val("en1",        {3'b0, ctrl_if.en1},       {3'b0, !(active && m_gated)});
      chk_val("rst_n_seq",  {3'b0, ctrl_if.rst_n_seq}, {3'b0, active});
      chk_val("gate_ack",   {3'b0, ctrl_if.gate_ack},  {3'b0, active && m_gated && !m_auto});
      chk_val("auto_gated", {3'b0, ctrl_if.auto_gated}, {3'b0, active && m_gated && m_auto});
   endtask

   task automatic step(input string ph);
      @(posedge clk1);
      #1;
      model_edge(sw_r, gr_r, bz_r);
      check_outputs();
      $display("%s edge=%0d sw=%b gr=%b busy=%b : state=%0d en1=%b rst_n_seq=%b ack=%b auto=%b",
               ph, e, sw_r, gr_r, bz_r, ctrl_if.state_o, ctrl_if.en1,
               ctrl_if.rst_n_seq, ctrl_if.gate_ack, ctrl_if.auto_gated);
   endtask

   task automatic reset_vals(input string tag);
      chk_val({tag, "_state_o"},    {1'b0, ctrl_if.state_o},   4'd0);
      chk_val({tag, "_en1"},        {3'b0, ctrl_if.en1},        4'd1);
      chk_val({tag, "_rst_n_seq"},  {3'b0, ctrl_if.rst_n_seq},  4'd0);
      chk_val({tag, "_gate_ack"},   {3'b0, ctrl_if.gate_ack},   4'd0);
      chk_val({tag, "_auto_gated"}, {3'b0, ctrl_if.auto_gated}, 4'd0);
   endtask

   // Asserts rst_n1 between edges, checks the immediate response, then
   // releases it just after an edge so the next edge is edge 1.
   task automatic apply_reset(input string tag);
      rst_n1 = 1'b0;
      #1;
      reset_vals({tag, "_async"});
      sw_r = 1'b0;
      gr_r = 1'b0;
      bz_r = 1'b0;
      repeat (3) @(posedge clk1);
      #1;
      reset_vals({tag, "_held"});
      model_reset();
      rst_n1 = 1'b1;
      $display("reset %s released", tag);
   endtask

   initial begin
      model_reset();
      #2;
      apply_reset("por");
      repeat (12) step("startup");

      gr_r = 1'b1;
      bz_r = 1'b0;
      repeat (3) step("gate");
      gr_r = 1'b0;
      step("ungate");

      gr_r = 1'b1;
      bz_r = 1'b1;
      repeat (5) step("drain_busy");
      gr_r = 1'b0;
      step("drain_abort");
      step("after_abort");

      gr_r = 1'b1;
      bz_r = 1'b0;
      repeat (3) step("gate2");
      sw_r = 1'b1;
      gr_r = 1'b0;
      step("sw_rst");
      sw_r = 1'b0;
      repeat (3) step("hold");
      sw_r = 1'b1;
      step("hold_ext");
      sw_r = 1'b0;
      repeat (9) step("hold");

      gr_r = 1'b0;
      bz_r = 1'b0;
      repeat (20) step("idle");
      bz_r = 1'b1;
      repeat (2) step("wake");

      for (int i = 0; i < 400; i++) begin
         sw_r = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) gr_r = !gr_r;
         if ($urandom_range(0, 5) == 0) bz_r = !bz_r;
         step("rand");
      end
      sw_r = 1'b0;

      gr_r = 1'b0;
      bz_r = 1'b1;
      repeat (2) step("settle");
      gr_r = 1'b1;
      repeat (2) step("pre_arst");
      #3;
      apply_reset("mid_drain");
      repeat (12) step("restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
